// File: rtl/ws2812_bit_driver.sv
// WS2812 NRZ serial driver: fetches 24-bit colour words on request and shifts
// them out MSB-first as timed high/low pulses, ending each frame with a latch gap.
module ws2812_bit_driver #(
    parameter int T0H_CYC  = 19,
    parameter int T1H_CYC  = 38,
    parameter int TBIT_CYC = 60,
    parameter int TRES_CYC = 14400
) (
    input  logic        clk_sb,
    input  logic        reset,
    input  logic        send_leds_n,
    input  logic [23:0] rgb_data_in,
    output logic        ws2812_next_led,
    output logic        ws2812_dout,
    output logic        busy
);

    localparam logic [15:0] TBIT_LAST = 16'(TBIT_CYC - 1);
    localparam logic [15:0] TRES_LAST = 16'(TRES_CYC - 1);
    localparam logic [4:0]  MSB_IDX   = 5'd23;

    // STROBE holds the request cycle so the translator has one cycle to update
    // the word before FETCH captures it.
    typedef enum logic [2:0] {IDLE, STROBE, FETCH, BIT, LATCH} state_t;

    state_t      state, state_nxt;
    logic [23:0] shift_q, shift_nxt;
    logic [4:0]  bit_idx, bit_idx_nxt;
    logic [15:0] phase, phase_nxt;
    logic [15:0] lat_cnt, lat_cnt_nxt;
    logic        more, more_nxt;
    logic        next_led_nxt;
    logic        dout_nxt;
    logic        busy_nxt;

    function automatic logic [15:0] high_cyc(input logic bit_val);
        return bit_val ? 16'(T1H_CYC) : 16'(T0H_CYC);
    endfunction

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift_q;
        bit_idx_nxt  = bit_idx;
        phase_nxt    = phase;
        lat_cnt_nxt  = lat_cnt;
        more_nxt     = more;
        next_led_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (!send_leds_n) begin
                    state_nxt    = STROBE;
                    next_led_nxt = 1'b1;
                end
            end
            STROBE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                shift_nxt   = rgb_data_in;
                bit_idx_nxt = MSB_IDX;
                phase_nxt   = '0;
                state_nxt   = BIT;
            end
            BIT: begin
                if (phase != TBIT_LAST) begin
                    phase_nxt = phase + 16'd1;
                end else if (bit_idx != 5'd0) begin
                    bit_idx_nxt = bit_idx - 5'd1;
                    phase_nxt   = '0;
                    // Registered strobe lands in the first cycle of bit 0.
                    if (bit_idx == 5'd1) begin
                        more_nxt     = !send_leds_n;
                        next_led_nxt = !send_leds_n;
                    end
                end else if (more) begin
                    shift_nxt   = rgb_data_in;
                    bit_idx_nxt = MSB_IDX;
                    phase_nxt   = '0;
                end else begin
                    lat_cnt_nxt = '0;
                    state_nxt   = LATCH;
                end
            end
            LATCH: begin
                if (lat_cnt == TRES_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    lat_cnt_nxt = lat_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        dout_nxt = (state_nxt == BIT) && (phase_nxt < high_cyc(shift_nxt[bit_idx_nxt]));
    end

    always_ff @(posedge clk_sb) begin
        if (reset) begin
            state           <= IDLE;
            shift_q         <= '0;
            bit_idx         <= '0;
            phase           <= '0;
            lat_cnt         <= '0;
            more            <= 1'b0;
            ws2812_next_led <= 1'b0;
            ws2812_dout     <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            shift_q         <= shift_nxt;
            bit_idx         <= bit_idx_nxt;
            phase           <= phase_nxt;
            lat_cnt         <= lat_cnt_nxt;
            more            <= more_nxt;
            ws2812_next_led <= next_led_nxt;
            ws2812_dout     <= dout_nxt;
            busy            <= busy_nxt;
        end
    end

endmodule
